// File: rtl/counter_pkg.sv
// counter_pkg: shared types for counter and timer blocks.
//   cnt_mode_t : CNT_WRAP (0) wraps at the limits, CNT_SAT (1) holds at the limits.
//   cnt_dir_t  : CNT_DOWN (0) counts down, CNT_UP (1) counts up.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_t;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_t;

endpackage

// File: rtl/updown_counter_if.sv
// updown_counter_if: control and result bundle of the up/down counter.
//   en    : count enable (advances the prescaler)
//   ld    : synchronous load of v
//   v     : load value, WIDTH bits
//   dir   : counting direction (cnt_dir_t)
//   mode  : wrap or saturate (cnt_mode_t)
//   count : registered count, WIDTH bits
//   tc    : registered terminal-count pulse
// master = the control/stimulus side, slave = the counter itself.
interface updown_counter_if #(
  parameter int WIDTH = 8
);
  import counter_pkg::*;

  logic             en;
  logic             ld;
  logic [WIDTH-1:0] v;
  cnt_dir_t         dir;
  cnt_mode_t        mode;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (output en, ld, v, dir, mode, input count, tc);
  modport slave  (input en, ld, v, dir, mode, output count, tc);

endinterface

// File: rtl/updown_counter_prescaler.sv
// prescaler: divides the enable into one tick every PRESCALE enabled cycles.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, phase -> 0
//   clr  : synchronous clear, phase -> 0; suppresses the tick
//   en   : advance the phase; the phase holds while en is low
//   tick : en & (phase == PRESCALE-1) & ~clr
// With PRESCALE=1 the phase register is constant 0 and tick follows en.
module prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic          at_last;

  assign at_last = (phase_q == LAST);
  assign tick    = en & ~clr & at_last;

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = at_last ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/updown_counter.sv
// updown_counter: modulo-(MAX+1) up/down counter with load, wrap/saturate
// modes, enable prescaler and a one-cycle terminal-count pulse.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (count, tc, prescaler -> 0)
//   bus : updown_counter_if slave (en, ld, v, dir, mode in; count, tc out)
// Priority per cycle: rst > ld > step > hold.
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             step;
  logic             at_limit;

  // A load clears the prescaler, so a load cycle never produces a step.
  prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.ld),
    .en   (bus.en),
    .tick (step)
  );

  // Terminal value depends on the direction currently requested.
  assign at_limit = (bus.dir == CNT_UP) ? (count_q == MAX_V) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.ld) begin
      count_d = (bus.v > MAX_V) ? MAX_V : bus.v;
    end else if (step) begin
      if (at_limit) begin
        // Pulse on every step taken at the limit, in both modes.
        tc_d = 1'b1;
        if (bus.mode == CNT_WRAP) begin
          count_d = (bus.dir == CNT_UP) ? '0 : MAX_V;
        end
      end else begin
        count_d = (bus.dir == CNT_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter. Three instances share one stimulus stream:
//   a: WIDTH=4, MAX=9,   PRESCALE=1
//   b: WIDTH=4, MAX=9,   PRESCALE=3
//   c: WIDTH=8, MAX=255, PRESCALE=1
// A behavioural model tracks all three and is compared every cycle; directed
// literal expectations pin the model at the interesting points.
module tb_updown_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       ld  = 1'b0;
  logic [7:0] v8  = 8'd0;
  logic       dir = 1'b1;
  logic       mode = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  updown_counter_if #(.WIDTH(4)) if_a ();
  updown_counter_if #(.WIDTH(4)) if_b ();
  updown_counter_if #(.WIDTH(8)) if_c ();

  assign if_a.en = en;  assign if_a.ld = ld;  assign if_a.v = v8[3:0];
  assign if_a.dir = cnt_dir_t'(dir);  assign if_a.mode = cnt_mode_t'(mode);
  assign if_b.en = en;  assign if_b.ld = ld;  assign if_b.v = v8[3:0];
  assign if_b.dir = cnt_dir_t'(dir);  assign if_b.mode = cnt_mode_t'(mode);
  assign if_c.en = en;  assign if_c.ld = ld;  assign if_c.v = v8;
  assign if_c.dir = cnt_dir_t'(dir);  assign if_c.mode = cnt_mode_t'(mode);

  updown_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  updown_counter #(.WIDTH(4), .MAX(9), .PRESCALE(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  updown_counter #(.WIDTH(8), .MAX(255), .PRESCALE(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  // ---------------- behavioural model ----------------
  int MX [3] = '{9, 9, 255};
  int PS [3] = '{1, 3, 1};
  int m_cnt [3] = '{0, 0, 0};
  int m_tc  [3] = '{0, 0, 0};
  int m_ph  [3] = '{0, 0, 0};

  function automatic int load_in(input int k);
    return (k == 2) ? int'(v8) : int'(v8[3:0]);
  endfunction

  function automatic int next_cnt(input int cnt, input int mx, input logic up, input logic sat);
    if (up) return (cnt < mx) ? cnt + 1 : (sat ? mx : 0);
    else    return (cnt > 0)  ? cnt - 1 : (sat ? 0 : mx);
  endfunction

  function automatic int limit_hit(input int cnt, input int mx, input logic up);
    return (up ? (cnt == mx) : (cnt == 0)) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_cnt[k] <= 0; m_tc[k] <= 0; m_ph[k] <= 0;
      end else if (ld) begin
        m_cnt[k] <= (load_in(k) > MX[k]) ? MX[k] : load_in(k);
        m_tc[k]  <= 0; m_ph[k] <= 0;
      end else if (en && m_ph[k] == PS[k] - 1) begin
        m_cnt[k] <= next_cnt(m_cnt[k], MX[k], dir, mode);
        m_tc[k]  <= limit_hit(m_cnt[k], MX[k], dir);
        m_ph[k]  <= 0;
      end else begin
        m_tc[k] <= 0;
        if (en) m_ph[k] <= m_ph[k] + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("a_count_model", int'(if_a.count), m_cnt[0]);
    chk("a_tc_model",    int'(if_a.tc),    m_tc[0]);
    chk("b_count_model", int'(if_b.count), m_cnt[1]);
    chk("b_tc_model",    int'(if_b.tc),    m_tc[1]);
    chk("c_count_model", int'(if_c.count), m_cnt[2]);
    chk("c_tc_model",    int'(if_c.tc),    m_tc[2]);
    chk("a_count_le_max", (int'(if_a.count) <= 9) ? 1 : 0, 1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  int exp1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp2 [5]  = '{1, 0, 0, 0, 0};
  int exp2t [5] = '{0, 0, 1, 1, 1};
  int exp4 [9]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
  int pulses;
  int maxc;

  initial begin
    // 1. reset and wrap up
    rst = 1'b1; tick(); tick();
    chk("reset_count", int'(if_a.count), 0);
    chk("reset_tc", int'(if_a.tc), 0);
    $display("txn reset: count=%0d tc=%0d", if_a.count, if_a.tc);
    rst = 1'b0; en = 1'b1; dir = 1'b1; mode = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("wrap_up_count", int'(if_a.count), exp1[i]);
      chk("wrap_up_tc", int'(if_a.tc), (i == 9) ? 1 : 0);
      $display("txn wrap_up %0d: count=%0d tc=%0d", i, if_a.count, if_a.tc);
    end

    // 2. saturate down from a load of 2
    ld = 1'b1; v8 = 8'd2; en = 1'b0; tick();
    chk("load2_count", int'(if_a.count), 2);
    ld = 1'b0; en = 1'b1; dir = 1'b0; mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_down_count", int'(if_a.count), exp2[i]);
      chk("sat_down_tc", int'(if_a.tc), exp2t[i]);
      $display("txn sat_down %0d: count=%0d tc=%0d", i, if_a.count, if_a.tc);
    end

    // 3. load clamp, load beats enable, reset beats load
    ld = 1'b1; en = 1'b1; v8 = 8'd13; tick();
    chk("clamp_count", int'(if_a.count), 9);
    chk("clamp_tc", int'(if_a.tc), 0);
    chk("noclamp_c", int'(if_c.count), 13);
    $display("txn clamp: a=%0d c=%0d", if_a.count, if_c.count);
    rst = 1'b1; tick();
    chk("rst_over_ld", int'(if_a.count), 0);
    chk("rst_over_ld_c", int'(if_c.count), 0);
    $display("txn rst+ld: a=%0d", if_a.count);
    rst = 1'b0;

    // 5. direction flip at the boundary
    ld = 1'b1; v8 = 8'd9; en = 1'b0; dir = 1'b1; mode = 1'b0; tick();
    ld = 1'b0; en = 1'b1; dir = 1'b0; tick();
    chk("flip_count", int'(if_a.count), 8);
    chk("flip_tc", int'(if_a.tc), 0);
    $display("txn flip: count=%0d tc=%0d", if_a.count, if_a.tc);
    ld = 1'b1; v8 = 8'd0; en = 1'b0; tick();
    ld = 1'b0; en = 1'b1; tick();
    chk("down_wrap_count", int'(if_a.count), 9);
    chk("down_wrap_tc", int'(if_a.tc), 1);
    $display("txn down_wrap: count=%0d tc=%0d", if_a.count, if_a.tc);
    en = 1'b0;

    // 4. prescaler (instance b)
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; dir = 1'b1; mode = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("presc_count", int'(if_b.count), exp4[i]);
      $display("txn presc cycle %0d: count=%0d", i + 1, if_b.count);
    end
    rst = 1'b1; en = 1'b0; tick(); rst = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      en = (i == 8 || i == 9) ? 1'b0 : 1'b1;
      tick();
      chk("presc_gap_count", int'(if_b.count), (i >= 11) ? 3 : (i >= 6 ? 2 : i / 3));
      $display("txn presc_gap cycle %0d: en=%0d count=%0d", i, en, if_b.count);
    end

    // 6. full-range wrap on the 8-bit instance
    rst = 1'b1; en = 1'b0; tick(); rst = 1'b0;
    en = 1'b1; dir = 1'b1; mode = 1'b0;
    pulses = 0; maxc = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (if_c.tc) pulses++;
      if (int'(if_c.count) > maxc) maxc = int'(if_c.count);
    end
    en = 1'b0;
    chk("full_range_count", int'(if_c.count), 0);
    chk("full_range_pulses", pulses, 1);
    chk("full_range_max", maxc, 255);
    $display("txn full_range: count=%0d pulses=%0d max=%0d", if_c.count, pulses, maxc);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
